// File: rtl/opt_kuznechik_pkg.sv
// Kuznechik (GOST R 34.12-2015) cipher constants and transform helpers.
// Holds the pi S-box, the l coefficients, the GF(2^8) polynomial and the round constants C1..C32.
// C1..C32 are computed by a constant function while the design is elaborated, so no logic is built for them.
package opt_kuznechik_pkg;

   typedef logic [127:0] block_t;
   typedef logic [255:0] key_t;

   // Field polynomial x^8+x^7+x^6+x+1.
   localparam logic [8:0] GF_POLY = 9'h1C3;

   // l coefficients. Entry 0 multiplies byte a15 and entry 15 multiplies byte a0.
   localparam logic [7:0] L_COEF [16] = '{
      8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
   };

   // The pi substitution table.
   localparam logic [7:0] PI [256] = '{
      8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
      8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
      8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
      8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
      8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
      8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
      8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
      8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
      8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
      8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
      8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
      8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
      8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
      8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
      8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
      8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
   };

   // Shift-and-add multiply in GF(2^8). With a constant operand this reduces to a few XORs.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = '0;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         if (x[7]) x = (x << 1) ^ GF_POLY[7:0];
         else      x = x << 1;
         y = y >> 1;
      end
      return p;
   endfunction

   // Linear form l over the 16 bytes of the block.
   function automatic logic [7:0] l_func(input block_t a);
      logic [7:0] acc;
      acc = '0;
      for (int j = 0; j < 16; j++)
         acc = acc ^ gf_mul(a[8*j +: 8], L_COEF[4'(15 - j)]);
      return acc;
   endfunction

   // R: shift right by one byte and put l(a) in the top byte.
   function automatic block_t r_step(input block_t a);
      return {l_func(a), a[127:8]};
   endfunction

   // L: sixteen applications of R.
   function automatic block_t l_transform(input block_t a);
      block_t t;
      t = a;
      for (int i = 0; i < 16; i++) t = r_step(t);
      return t;
   endfunction

   // S: bytewise pi substitution.
   function automatic block_t s_transform(input block_t a);
      block_t t;
      t = '0;
      for (int j = 0; j < 16; j++) t[8*j +: 8] = PI[a[8*j +: 8]];
      return t;
   endfunction

   // C_i = L(i) for i = 1..32. C_i is stored at bits [(i-1)*128 +: 128].
   function automatic logic [32*128-1:0] gen_round_consts();
      logic [32*128-1:0] tab;
      block_t v;
      tab = '0;
      for (int i = 1; i <= 32; i++) begin
         v = '0;
         v[7:0] = 8'(i);
         tab[(i-1)*128 +: 128] = l_transform(v);
      end
      return tab;
   endfunction

   localparam logic [32*128-1:0] C_TAB = gen_round_consts();

endpackage

// File: rtl/opt_kuznechik_lsx.sv
// One Kuznechik LSX step: result = L(S(data ^ round_key)).
// Purely combinational. The same step serves the key schedule Feistel and the cipher rounds.
module opt_kuznechik_lsx
   import opt_kuznechik_pkg::*;
(
   input  logic [127:0] data,
   input  logic [127:0] round_key,
   output logic [127:0] result
);

   block_t x_val;
   block_t s_val;

   assign x_val  = data ^ round_key;
   assign s_val  = s_transform(x_val);
   assign result = l_transform(s_val);

endmodule

// File: rtl/opt_kuznechik_encoder.sv
// Single-block Kuznechik encryption: a 32-step key schedule and 9 LSX rounds plus a final key XOR, in one cone.
// Latency is 0 by default. Defining OPT_KUZNECHIK_OUT_REG_EN adds a 128-bit output register: latency 1, sync reset to 0.
// There is no handshake. Every input combination is a valid request and a new block is accepted each cycle.
module opt_kuznechik_encoder
   import opt_kuznechik_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] block,
   input  logic [255:0] key,
   output logic [127:0] encoded
);

   block_t ct;

   // Key schedule. Each step is one Feistel round F[C_{s+1}]: (a1, a0) -> (LSX[C](a1) ^ a0, a1).
   // After steps 7, 15, 23 and 31 the pair (a1, a0) gives (K3,K4), (K5,K6), (K7,K8) and (K9,K10).
   for (genvar s = 0; s < 32; s++) begin : g_ks
      localparam block_t CS = C_TAB[s*128 +: 128];
      block_t a1_in;
      block_t a0_in;
      block_t f_out;
      block_t a1_out;
      block_t a0_out;
      if (s == 0) begin : g_first
         assign a1_in = key[255:128];
         assign a0_in = key[127:0];
      end else begin : g_next
         assign a1_in = g_ks[s-1].a1_out;
         assign a0_in = g_ks[s-1].a0_out;
      end
      opt_kuznechik_lsx u_lsx (
         .data      (a1_in),
         .round_key (CS),
         .result    (f_out)
      );
      assign a1_out = f_out ^ a0_in;
      assign a0_out = a1_in;
   end

   // Cipher rounds 1..9 use K1..K9. K1 and K2 come straight from the master key.
   for (genvar r = 1; r <= 9; r++) begin : g_rnd
      block_t rk;
      block_t st_in;
      block_t st_out;
      if (r == 1) begin : g_k1
         assign rk = key[255:128];
      end else if (r == 2) begin : g_k2
         assign rk = key[127:0];
      end else if (r % 2 == 1) begin : g_kodd
         assign rk = g_ks[8*((r-1)/2)-1].a1_out;
      end else begin : g_keven
         assign rk = g_ks[8*((r-2)/2)-1].a0_out;
      end
      if (r == 1) begin : g_src_block
         assign st_in = block;
      end else begin : g_src_prev
         assign st_in = g_rnd[r-1].st_out;
      end
      opt_kuznechik_lsx u_lsx (
         .data      (st_in),
         .round_key (rk),
         .result    (st_out)
      );
   end

   // The final whitening XOR uses K10.
   assign ct = g_rnd[9].st_out ^ g_ks[31].a0_out;

`ifdef OPT_KUZNECHIK_OUT_REG_EN
   block_t enc_q;

   // Capture one ciphertext per cycle. Reset wins over capture and drops the in-flight block.
   always_ff @(posedge clk) begin
      if (rst) enc_q <= '0;
      else     enc_q <= ct;
   end

   assign encoded = enc_q;
`else
   // The combinational build uses no clock or reset. This tie-off keeps them formally used.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   assign encoded = ct;
`endif

endmodule

// File: tb/tb_opt_kuznechik_encoder.sv
// Directed bench for opt_kuznechik_encoder using the standard vector and published transform vectors.
// Checks the combinational build by default. With OPT_KUZNECHIK_OUT_REG_EN it also checks reset, 1-cycle lag and mid-stream reset.
module tb_opt_kuznechik_encoder;
   import opt_kuznechik_pkg::*;

   localparam logic [127:0] STD_PT  = 128'h1122334455667700ffeeddccbbaa9988;
   localparam logic [255:0] STD_KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
   localparam logic [127:0] STD_CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;

   // op: 0 = S, 1 = R, 2 = L, 3 = full encryption through the DUT
   typedef struct {
      int           op;
      logic [127:0] din;
      logic [255:0] k;
      logic [127:0] exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] block;
   logic [255:0] key;
   logic [127:0] encoded;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   opt_kuznechik_encoder dut (
      .clk     (clk),
      .rst     (rst),
      .block   (block),
      .key     (key),
      .encoded (encoded)
   );

   task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_ne(input string name, input logic [127:0] act, input logic [127:0] bad);
      checks++;
      if (act === bad || $isunknown(act)) begin
         failures++;
         $display("FAIL %s: got %h expected anything but %h", name, act, bad);
      end
   endtask

   initial begin
      vec_t tab [10];
      logic std_slot;
      logic prev_std;

      tab[0] = '{0, 128'hffeeddccbbaa99881122334455667700, '0, 128'hb66cd8887d38e8d77765aeea0c9a7efc};
      tab[1] = '{0, 128'hb66cd8887d38e8d77765aeea0c9a7efc, '0, 128'h559d8dd7bd06cbfe7e7b262523280d39};
      tab[2] = '{1, 128'h00000000000000000000000000000100, '0, 128'h94000000000000000000000000000001};
      tab[3] = '{1, 128'h94000000000000000000000000000001, '0, 128'ha5940000000000000000000000000000};
      tab[4] = '{1, 128'ha5940000000000000000000000000000, '0, 128'h64a59400000000000000000000000000};
      tab[5] = '{2, 128'h64a59400000000000000000000000000, '0, 128'hd456584dd0e3e84cc3166e4b7fa2890d};
      tab[6] = '{2, 128'h00000000000000000000000000000001, '0, 128'h6ea276726c487ab85d27bd10dd849401};
      tab[7] = '{2, 128'h00000000000000000000000000000002, '0, 128'hdc87ece4d890f4b3ba4eb92079cbeb02};
      tab[8] = '{3, STD_PT, STD_KEY, STD_CT};
      tab[9] = '{3, STD_PT, STD_KEY, STD_CT};

      // Hold reset for two edges with the standard vector applied.
      rst   = 1'b1;
      block = STD_PT;
      key   = STD_KEY;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
`ifdef OPT_KUZNECHIK_OUT_REG_EN
      check_eq("reset_hold", encoded, '0);
      rst = 1'b0;
      #1;
      check_eq("reset_release_no_edge", encoded, '0);
      @(posedge clk);
      #1;
      check_eq("first_after_reset", encoded, STD_CT);
      @(negedge clk);
`else
      check_eq("rst_has_no_effect", encoded, STD_CT);
      rst = 1'b0;
      #1;
      check_eq("std_vector_comb", encoded, STD_CT);
      @(negedge clk);
`endif

      // Table-driven checks: transform unit vectors and the full encryption.
      for (int i = 0; i < 10; i++) begin
         case (tab[i].op)
            0: check_eq($sformatf("vec%0d_S", i), s_transform(tab[i].din), tab[i].exp);
            1: check_eq($sformatf("vec%0d_R", i), r_step(tab[i].din), tab[i].exp);
            2: check_eq($sformatf("vec%0d_L", i), l_transform(tab[i].din), tab[i].exp);
            default: begin
               block = tab[i].din;
               key   = tab[i].k;
               @(posedge clk);
               @(negedge clk);
               check_eq($sformatf("vec%0d_enc", i), encoded, tab[i].exp);
            end
         endcase
      end

      // Flipping key bit 0 must change the ciphertext. Restoring the key must bring the original back.
      key = STD_KEY ^ 256'd1;
      @(posedge clk);
      @(negedge clk);
      check_ne("key_bit0_flip", encoded, STD_CT);
      key = STD_KEY;
`ifdef OPT_KUZNECHIK_OUT_REG_EN
      @(posedge clk);
      @(negedge clk);
`else
      #1;
`endif
      check_eq("key_restore", encoded, STD_CT);
      @(negedge clk);
      block = STD_PT ^ {1'b1, 127'd0};
      @(posedge clk);
      @(negedge clk);
      check_ne("block_msb_flip", encoded, STD_CT);

      // Alternate the standard block and its inverse on every cycle. In the registered build, reset is pulsed at slot 5.
      prev_std = 1'b0;
      for (int c = 0; c < 10; c++) begin
         std_slot = (c % 2 == 0);
         block    = std_slot ? STD_PT : ~STD_PT;
`ifdef OPT_KUZNECHIK_OUT_REG_EN
         rst = (c == 5);
         #1;
         if (c > 0) begin
            if (c - 1 == 5)    check_eq($sformatf("lag_slot%0d", c), encoded, '0);
            else if (prev_std) check_eq($sformatf("lag_slot%0d", c), encoded, STD_CT);
            else               check_ne($sformatf("lag_slot%0d", c), encoded, STD_CT);
         end
         @(posedge clk);
         #1;
         if (c == 5)        check_eq("midstream_reset", encoded, '0);
         else if (std_slot) check_eq($sformatf("stream_slot%0d", c), encoded, STD_CT);
         else               check_ne($sformatf("stream_slot%0d", c), encoded, STD_CT);
         @(negedge clk);
         rst = 1'b0;
`else
         #1;
         if (std_slot) check_eq($sformatf("stream_slot%0d", c), encoded, STD_CT);
         else          check_ne($sformatf("stream_slot%0d", c), encoded, STD_CT);
         @(negedge clk);
`endif
         prev_std = std_slot;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
